// File: rtl/pulse_meter_pkg.sv
// Shared types and default constants for the pulse_meter measurement block.
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } meter_state_t;

    localparam int GATE_CYCLES_1MS = 100000;
    localparam int TIMEOUT_DEFAULT = 65535;

endpackage

// File: rtl/pulse_meter_gate.sv
// Fixed-length gate counter: counts rising edges per window and publishes the total.
module pulse_meter_gate
    import pulse_meter_pkg::*;
#(
    parameter int GATE_CYCLES = GATE_CYCLES_1MS,
    parameter int FREQ_W      = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              rise,
    output logic [FREQ_W-1:0] freq_khz,
    output logic              freq_valid
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic [GATE_W-1:0] gate_cnt;
    logic [FREQ_W-1:0] edge_cnt;
    logic [FREQ_W-1:0] edge_inc;

    // Edge total including the current cycle, pinned at all-ones.
    assign edge_inc = (rise && !(&edge_cnt)) ? edge_cnt + 1'b1 : edge_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            freq_khz   <= '0;
            freq_valid <= 1'b0;
        end else if (!enable) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            freq_khz   <= '0;
            freq_valid <= 1'b0;
        end else if (gate_cnt == GATE_LAST) begin
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            freq_khz   <= edge_inc;
            freq_valid <= 1'b1;
        end else begin
            gate_cnt   <= gate_cnt + 1'b1;
            edge_cnt   <= edge_inc;
            freq_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pulse_meter.sv
// Period / high-time / frequency meter with loss-of-signal detection.
//   state   | meaning
//   IDLE    | disabled, everything cleared
//   ARM     | waiting for a reference rising edge
//   MEAS    | timing the current period from the last rise
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int GATE_CYCLES    = GATE_CYCLES_1MS,
    parameter int FREQ_W         = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              pulse_in,
    output logic [CNT_W-1:0]  period_cycles,
    output logic [CNT_W-1:0]  high_cycles,
    output logic              meas_valid,
    output logic [FREQ_W-1:0] freq_khz,
    output logic              freq_valid,
    output logic              no_signal
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYCLES);

    meter_state_t     state, state_nxt;
    logic             pulse_d;
    logic             rise, fall;
    logic [CNT_W-1:0] per_cnt, per_cnt_nxt;
    logic [CNT_W-1:0] hi_lat, hi_lat_nxt;
    logic [CNT_W-1:0] period_nxt, high_nxt;
    logic             mv_nxt, nosig_nxt;

    assign rise = pulse_in & ~pulse_d;
    assign fall = ~pulse_in & pulse_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_d       <= 1'b0;
            state         <= ST_IDLE;
            per_cnt       <= '0;
            hi_lat        <= '0;
            period_cycles <= '0;
            high_cycles   <= '0;
            meas_valid    <= 1'b0;
            no_signal     <= 1'b0;
        end else begin
            pulse_d       <= pulse_in;
            state         <= state_nxt;
            per_cnt       <= per_cnt_nxt;
            hi_lat        <= hi_lat_nxt;
            period_cycles <= period_nxt;
            high_cycles   <= high_nxt;
            meas_valid    <= mv_nxt;
            no_signal     <= nosig_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        per_cnt_nxt = per_cnt;
        hi_lat_nxt  = hi_lat;
        period_nxt  = period_cycles;
        high_nxt    = high_cycles;
        mv_nxt      = 1'b0;
        nosig_nxt   = no_signal;
        if (!enable) begin
            state_nxt   = ST_IDLE;
            per_cnt_nxt = '0;
            hi_lat_nxt  = '0;
            period_nxt  = '0;
            high_nxt    = '0;
            nosig_nxt   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_ARM;
                ST_ARM: begin
                    if (rise) begin
                        per_cnt_nxt = CNT_W'(1);
                        nosig_nxt   = 1'b0;
                        state_nxt   = ST_MEAS;
                    end
                end
                ST_MEAS: begin
                    // A rise on the timeout cycle still counts as a valid period.
                    if (rise) begin
                        period_nxt  = per_cnt;
                        high_nxt    = hi_lat;
                        mv_nxt      = 1'b1;
                        per_cnt_nxt = CNT_W'(1);
                    end else if (per_cnt == TIMEOUT_V) begin
                        nosig_nxt   = 1'b1;
                        period_nxt  = '0;
                        high_nxt    = '0;
                        per_cnt_nxt = '0;
                        state_nxt   = ST_ARM;
                    end else begin
                        per_cnt_nxt = per_cnt + 1'b1;
                        if (fall) hi_lat_nxt = per_cnt;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    pulse_meter_gate #(
        .GATE_CYCLES (GATE_CYCLES),
        .FREQ_W      (FREQ_W)
    ) u_gate (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .rise       (rise),
        .freq_khz   (freq_khz),
        .freq_valid (freq_valid)
    );

endmodule

// File: tb/tb_pulse_meter.sv
// Randomised scoreboard bench for pulse_meter against a timestamp-based reference model.
module tb_pulse_meter;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 300;
    localparam int GATE    = 1000;
    localparam int FREQ_W  = 8;
    localparam int FREQ_MAX = (1 << FREQ_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic pulse_in = 1'b0;
    logic [CNT_W-1:0]  period_cycles, high_cycles;
    logic [FREQ_W-1:0] freq_khz;
    logic meas_valid, freq_valid, no_signal;

    pulse_meter #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT),
        .GATE_CYCLES    (GATE),
        .FREQ_W         (FREQ_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .pulse_in      (pulse_in),
        .period_cycles (period_cycles),
        .high_cycles   (high_cycles),
        .meas_valid    (meas_valid),
        .freq_khz      (freq_khz),
        .freq_valid    (freq_valid),
        .no_signal     (no_signal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int a;
        int b;
    } ev_t;

    ev_t meas_q[$];
    ev_t freq_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int meas_seen = 0;
    int freq_seen = 0;

    // reference model state: timestamps of the last rise/fall and window tallies
    int   exp_period = 0, exp_high = 0, exp_freq = 0, exp_nosig = 0;
    bit   m_active = 0, m_have_ref = 0;
    logic m_prev = 1'b0;
    int   last_rise = 0, last_fall = 0, gate_pos = 0, edges = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
            if (errors >= 40) begin
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    endtask

    task m_clear();
        m_active   = 0;
        m_have_ref = 0;
        exp_period = 0;
        exp_high   = 0;
        exp_freq   = 0;
        exp_nosig  = 0;
        gate_pos   = 0;
        edges      = 0;
    endtask

    initial begin : model
        bit r, f;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_clear();
                m_prev = 1'b0;
                meas_q.delete();
                freq_q.delete();
            end else begin
                cyc++;
                r = pulse_in && !m_prev;
                f = !pulse_in && m_prev;
                m_prev = pulse_in;
                if (!enable) begin
                    m_clear();
                end else begin
                    if (!m_active) begin
                        m_active = 1;
                    end else if (r) begin
                        if (m_have_ref) begin
                            exp_period = cyc - last_rise;
                            exp_high   = last_fall - last_rise;
                            meas_q.push_back('{cyc, exp_period, exp_high});
                        end
                        exp_nosig  = 0;
                        m_have_ref = 1;
                        last_rise  = cyc;
                    end else if (m_have_ref) begin
                        if (f) last_fall = cyc;
                        if (cyc - last_rise == TIMEOUT) begin
                            exp_nosig  = 1;
                            exp_period = 0;
                            exp_high   = 0;
                            m_have_ref = 0;
                        end
                    end
                    if (r) edges++;
                    gate_pos++;
                    if (gate_pos == GATE) begin
                        exp_freq = (edges > FREQ_MAX) ? FREQ_MAX : edges;
                        freq_q.push_back('{cyc, exp_freq, 0});
                        edges    = 0;
                        gate_pos = 0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        bit exp_mv, exp_fv;
        ev_t e;
        forever begin
            @(negedge clk);
            chk("no_signal", longint'(no_signal), longint'(exp_nosig));
            chk("period_hold", longint'(period_cycles), longint'(exp_period));
            chk("high_hold", longint'(high_cycles), longint'(exp_high));
            chk("freq_hold", longint'(freq_khz), longint'(exp_freq));
            exp_mv = (meas_q.size() != 0) && (meas_q[0].cyc == cyc);
            chk("meas_valid", longint'(meas_valid), longint'(exp_mv));
            if (exp_mv) begin
                e = meas_q.pop_front();
                if (meas_valid) begin
                    meas_seen++;
                    chk("period", longint'(period_cycles), longint'(e.a));
                    chk("high", longint'(high_cycles), longint'(e.b));
                end
            end
            exp_fv = (freq_q.size() != 0) && (freq_q[0].cyc == cyc);
            chk("freq_valid", longint'(freq_valid), longint'(exp_fv));
            if (exp_fv) begin
                e = freq_q.pop_front();
                if (freq_valid) begin
                    freq_seen++;
                    chk("freq_khz", longint'(freq_khz), longint'(e.a));
                end
            end
        end
    end

    task automatic gen(input int per, input int hi, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pulse_in = ((i % per) < hi);
        end
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pulse_in = v;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period"}, longint'(period_cycles), 0);
        chk({tag, "_high"}, longint'(high_cycles), 0);
        chk({tag, "_freq"}, longint'(freq_khz), 0);
        chk({tag, "_strobes"}, longint'({meas_valid, freq_valid}), 0);
        chk({tag, "_no_signal"}, longint'(no_signal), 0);
    endtask

    initial begin : stimulus
        int p, h;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        gen(33, 16, 2200);
        gen(33, 4, 700);
        gen(33, 8, 700);
        gen(10, 2, 1100);
        hold(1'b0, 400);
        gen(33, 16, 200);
        hold(1'b1, 400);
        hold(1'b0, 5);
        gen(33, 16, 200);
        gen(TIMEOUT, TIMEOUT / 2, 3 * TIMEOUT);
        gen(TIMEOUT + 1, 10, 3 * TIMEOUT);
        gen(2, 1, 2100);
        for (int k = 0; k < 6; k++) begin
            p = int'($urandom_range(2, 80));
            h = int'($urandom_range(1, p - 1));
            gen(p, h, int'($urandom_range(400, 900)));
        end
        gen(33, 16, 117);
        enable = 1'b0;
        gen(33, 16, 1);
        chk_all_zero("disable");
        gen(33, 16, 60);
        enable = 1'b1;
        gen(33, 16, 1300);
        gen(7, 3, 450);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        gen(7, 3, 4);
        rst_n = 1'b1;
        gen(33, 16, 1300);
        chk("meas_strobes_seen", longint'(meas_seen > 100), 1);
        chk("freq_strobes_seen", longint'(freq_seen > 8), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
